// File: rtl/rvfi_csr_pkg.sv
// rtl/rvfi_csr_pkg.sv - shared constants for the RVFI CSR counter block
// Holds the CSR address map, the Zicsr funct3[1:0] operation codes,
// the privilege-mode encodings and the decoded-target selector.
package rvfi_csr_pkg;

   // CSR addresses
   localparam logic [11:0] csr_misa      = 12'h301;
   localparam logic [11:0] csr_mcycle    = 12'hB00;
   localparam logic [11:0] csr_minstret  = 12'hB02;
   localparam logic [11:0] csr_mcycleh   = 12'hB80;
   localparam logic [11:0] csr_minstreth = 12'hB82;
   localparam logic [11:0] csr_cycle     = 12'hC00;
   localparam logic [11:0] csr_instret   = 12'hC02;
   localparam logic [11:0] csr_cycleh    = 12'hC80;
   localparam logic [11:0] csr_instreth  = 12'hC82;
   localparam logic [11:0] csr_none      = 12'hFFF;

   // funct3[1:0]; funct3[2] only selects the immediate operand
   localparam logic [1:0] f3_rw = 2'b01;
   localparam logic [1:0] f3_rs = 2'b10;
   localparam logic [1:0] f3_rc = 2'b11;

   // privilege modes
   localparam logic [1:0] mode_u = 2'd0;
   localparam logic [1:0] mode_s = 2'd1;
   localparam logic [1:0] mode_m = 2'd3;

   typedef enum logic [1:0] {
      sel_none    = 2'd0,
      sel_misa    = 2'd1,
      sel_cycle   = 2'd2,
      sel_instret = 2'd3
   } csr_sel_e;

endpackage

// File: rtl/rvfi_csr_counter64.sv
// rtl/rvfi_csr_counter64.sv - 64-bit counter with increment and bit-masked write
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   inc           : amount added this edge (0..3)
//   wmask, wdata  : bits in wmask take wdata instead of the incremented value
//   pre           : current count
//   post          : value the count takes at the next edge
module rvfi_csr_counter64 (
   input  logic        clock,
   input  logic        resetn,
   input  logic [1:0]  inc,
   input  logic [63:0] wmask,
   input  logic [63:0] wdata,
   output logic [63:0] pre,
   output logic [63:0] post
);

   logic [63:0] bumped;

   // Wrap from 2^64-1 to 0 is plain modular addition.
   assign bumped = pre + 64'(inc);
   assign post   = (bumped & ~wmask) | (wdata & wmask);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pre <= '0;
      end else begin
         pre <= post;
      end
   end

endmodule

// File: rtl/rvfi_csr_counters.sv
// rtl/rvfi_csr_counters.sv - Zicsr executor for misa/mcycle/minstret with RVFI CSR outputs
// Optional feature macro: RVFI_CSR_UCOUNTER_EN (read-only cycle/instret user aliases).
// Ports:
//   clock, resetn              : clock and asynchronous active-low reset
//   req_valid/req_ready        : CSR instruction handshake (insn, rs1 value, mode)
//   retire_other               : a non-CSR instruction retired this cycle
//   resp_valid/resp_ready      : registered result handshake
//   resp_trap/rd_addr/rd_wdata : instruction result
//   rvfi_csr_<csr>_*           : RVFI rmask/wmask/rdata/wdata for misa, mcycle, minstret
module rvfi_csr_counters
   import rvfi_csr_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_insn,
   input  logic [XLEN-1:0] req_rs1_rdata,
   input  logic [1:0]      req_mode,
   input  logic            retire_other,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            resp_trap,
   output logic [4:0]      resp_rd_addr,
   output logic [XLEN-1:0] resp_rd_wdata,
   output logic [XLEN-1:0] rvfi_csr_misa_rmask,
   output logic [XLEN-1:0] rvfi_csr_misa_wmask,
   output logic [XLEN-1:0] rvfi_csr_misa_rdata,
   output logic [XLEN-1:0] rvfi_csr_misa_wdata,
   output logic [63:0]     rvfi_csr_mcycle_rmask,
   output logic [63:0]     rvfi_csr_mcycle_wmask,
   output logic [63:0]     rvfi_csr_mcycle_rdata,
   output logic [63:0]     rvfi_csr_mcycle_wdata,
   output logic [63:0]     rvfi_csr_minstret_rmask,
   output logic [63:0]     rvfi_csr_minstret_wmask,
   output logic [63:0]     rvfi_csr_minstret_rdata,
   output logic [63:0]     rvfi_csr_minstret_wdata
);

   localparam logic [63:0] lo_mask = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                  : 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] hi_mask = 64'hFFFF_FFFF_0000_0000;

   logic [11:0]     addr;
   logic [4:0]      rs1_field;
   logic [4:0]      rd;
   logic [1:0]      op;
   logic            accept;
   logic            write;
   logic            trap;
   logic            hi;
   csr_sel_e        sel;
   logic            hit_cyc;
   logic            hit_ins;
   logic            hit_misa;
   logic [XLEN-1:0] arg;
   logic [XLEN-1:0] old_x;
   logic [XLEN-1:0] new_x;
   logic [63:0]     cnt_pre;
   logic [63:0]     part_mask;
   logic [63:0]     part_wdata;
   logic [63:0]     cyc_pre, cyc_post, cyc_wmask;
   logic [63:0]     ins_pre, ins_post, ins_wmask;
   logic [1:0]      ins_inc;
   logic            unused_opcode;

   assign addr          = req_insn[31:20];
   assign rs1_field     = req_insn[19:15];
   assign op            = req_insn[13:12];
   assign rd            = req_insn[11:7];
   assign unused_opcode = ^req_insn[6:0];

   assign req_ready = !resp_valid || resp_ready;
   assign accept    = req_valid && req_ready;
   // CSRRS/CSRRC with a zero source never write, so read-only CSRs stay readable.
   assign write     = !req_insn[13] || (rs1_field != 5'd0);
   assign arg       = req_insn[14] ? XLEN'(rs1_field) : req_rs1_rdata;

   always_comb begin
      sel = sel_none;
      hi  = 1'b0;
      case (addr)
         csr_misa:      sel = sel_misa;
         csr_mcycle:    sel = sel_cycle;
         csr_minstret:  sel = sel_instret;
         csr_mcycleh:   if (XLEN == 32) begin sel = sel_cycle;   hi = 1'b1; end
         csr_minstreth: if (XLEN == 32) begin sel = sel_instret; hi = 1'b1; end
`ifdef RVFI_CSR_UCOUNTER_EN
         csr_cycle:     sel = sel_cycle;
         csr_instret:   sel = sel_instret;
         csr_cycleh:    if (XLEN == 32) begin sel = sel_cycle;   hi = 1'b1; end
         csr_instreth:  if (XLEN == 32) begin sel = sel_instret; hi = 1'b1; end
`endif
         csr_none:      sel = sel_none;
         default:       sel = sel_none;
      endcase
   end

   // addr[9:8] is the lowest privilege allowed; addr[11:10]==11 marks read-only.
   assign trap = (sel == sel_none) || (req_mode < addr[9:8]) ||
                 ((addr[11:10] == 2'b11) && write);

   assign hit_misa = !trap && (sel == sel_misa);
   assign hit_cyc  = !trap && (sel == sel_cycle);
   assign hit_ins  = !trap && (sel == sel_instret);

   always_comb begin
      case (sel)
         sel_misa:    cnt_pre = 64'(MISA_VALUE);
         sel_cycle:   cnt_pre = cyc_pre;
         sel_instret: cnt_pre = ins_pre;
         default:     cnt_pre = '0;
      endcase
   end

   assign old_x = hi ? XLEN'(cnt_pre[63:32]) : cnt_pre[XLEN-1:0];

   always_comb begin
      case (op)
         f3_rw:   new_x = arg;
         f3_rs:   new_x = old_x | arg;
         f3_rc:   new_x = old_x & ~arg;
         default: new_x = old_x;
      endcase
   end

   assign part_mask  = hi ? hi_mask : lo_mask;
   assign part_wdata = hi ? {new_x[31:0], 32'h0} : 64'(new_x);

   assign cyc_wmask = (accept && hit_cyc && write) ? part_mask : '0;
   assign ins_wmask = (accept && hit_ins && write) ? part_mask : '0;
   // The retiring CSR instruction is the one whose response is handed over now.
   assign ins_inc   = {1'b0, retire_other} + {1'b0, resp_valid && resp_ready};

   rvfi_csr_counter64 u_mcycle (
      .clock  (clock),
      .resetn (resetn),
      .inc    (2'd1),
      .wmask  (cyc_wmask),
      .wdata  (part_wdata),
      .pre    (cyc_pre),
      .post   (cyc_post)
   );

   rvfi_csr_counter64 u_minstret (
      .clock  (clock),
      .resetn (resetn),
      .inc    (ins_inc),
      .wmask  (ins_wmask),
      .wdata  (part_wdata),
      .pre    (ins_pre),
      .post   (ins_post)
   );

   // misa is never writable.
   assign rvfi_csr_misa_wmask = '0;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         resp_valid              <= 1'b0;
         resp_trap               <= 1'b0;
         resp_rd_addr            <= '0;
         resp_rd_wdata           <= '0;
         rvfi_csr_misa_rmask     <= '0;
         rvfi_csr_misa_rdata     <= '0;
         rvfi_csr_misa_wdata     <= '0;
         rvfi_csr_mcycle_rmask   <= '0;
         rvfi_csr_mcycle_wmask   <= '0;
         rvfi_csr_mcycle_rdata   <= '0;
         rvfi_csr_mcycle_wdata   <= '0;
         rvfi_csr_minstret_rmask <= '0;
         rvfi_csr_minstret_wmask <= '0;
         rvfi_csr_minstret_rdata <= '0;
         rvfi_csr_minstret_wdata <= '0;
      end else if (accept) begin
         resp_valid              <= 1'b1;
         resp_trap               <= trap;
         resp_rd_addr            <= trap ? 5'd0 : rd;
         resp_rd_wdata           <= (trap || rd == 5'd0) ? '0 : old_x;
         rvfi_csr_misa_rmask     <= hit_misa ? '1 : '0;
         rvfi_csr_misa_rdata     <= hit_misa ? MISA_VALUE : '0;
         rvfi_csr_misa_wdata     <= hit_misa ? MISA_VALUE : '0;
         rvfi_csr_mcycle_rmask   <= hit_cyc ? part_mask : '0;
         rvfi_csr_mcycle_wmask   <= (hit_cyc && write) ? part_mask : '0;
         rvfi_csr_mcycle_rdata   <= hit_cyc ? cyc_pre : '0;
         rvfi_csr_mcycle_wdata   <= hit_cyc ? cyc_post : '0;
         rvfi_csr_minstret_rmask <= hit_ins ? part_mask : '0;
         rvfi_csr_minstret_wmask <= (hit_ins && write) ? part_mask : '0;
         rvfi_csr_minstret_rdata <= hit_ins ? ins_pre : '0;
         rvfi_csr_minstret_wdata <= hit_ins ? ins_post : '0;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rvfi_csr_counters.sv
// tb/tb_rvfi_csr_counters.sv - self-checking bench for rvfi_csr_counters (XLEN=32)
module tb_rvfi_csr_counters;
   import rvfi_csr_pkg::*;

   localparam logic [31:0] MISA = 32'h4000_0100;
   localparam logic [1:0]  S_NONE = 2'd0, S_MISA = 2'd1, S_CYC = 2'd2, S_INS = 2'd3;
`ifdef RVFI_CSR_UCOUNTER_EN
   localparam logic        USER_TRAP = 1'b0;
   localparam logic [1:0]  USER_SEL  = S_CYC;
`else
   localparam logic        USER_TRAP = 1'b1;
   localparam logic [1:0]  USER_SEL  = S_NONE;
`endif

   typedef struct {
      logic [1:0]  mode;
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [31:0] rs1_val;
      logic        trap;
      logic [1:0]  sel;
      logic        hi;
      logic        wr;
   } vec_t;

   typedef struct packed {
      logic        trap;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] misa_rmask, misa_rdata, misa_wdata;
      logic [63:0] cyc_rmask, cyc_wmask, cyc_rdata, cyc_wdata;
      logic [63:0] ins_rmask, ins_wmask, ins_rdata, ins_wdata;
   } exp_t;

   logic        clock = 1'b0;
   logic        resetn;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_insn = '0;
   logic [31:0] req_rs1_rdata = '0;
   logic [1:0]  req_mode = 2'd3;
   logic        retire_other = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic        resp_trap;
   logic [4:0]  resp_rd_addr;
   logic [31:0] resp_rd_wdata;
   logic [31:0] misa_rmask, misa_wmask, misa_rdata, misa_wdata;
   logic [63:0] cyc_rmask, cyc_wmask, cyc_rdata, cyc_wdata;
   logic [63:0] ins_rmask, ins_wmask, ins_rdata, ins_wdata;

   int          total = 0;
   int          bad = 0;
   logic [63:0] m_cyc = '0;
   logic [63:0] m_ins = '0;
   logic        m_rv = 1'b0;
   exp_t        sb[$];
   vec_t        cur;
   vec_t        tab[$];

   always #5 clock = ~clock;

   rvfi_csr_counters dut (
      .clock(clock), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
      .req_rs1_rdata(req_rs1_rdata), .req_mode(req_mode), .retire_other(retire_other),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_trap(resp_trap),
      .resp_rd_addr(resp_rd_addr), .resp_rd_wdata(resp_rd_wdata),
      .rvfi_csr_misa_rmask(misa_rmask), .rvfi_csr_misa_wmask(misa_wmask),
      .rvfi_csr_misa_rdata(misa_rdata), .rvfi_csr_misa_wdata(misa_wdata),
      .rvfi_csr_mcycle_rmask(cyc_rmask), .rvfi_csr_mcycle_wmask(cyc_wmask),
      .rvfi_csr_mcycle_rdata(cyc_rdata), .rvfi_csr_mcycle_wdata(cyc_wdata),
      .rvfi_csr_minstret_rmask(ins_rmask), .rvfi_csr_minstret_wmask(ins_wmask),
      .rvfi_csr_minstret_rdata(ins_rdata), .rvfi_csr_minstret_wdata(ins_wdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] mode, input logic [2:0] f3,
                               input logic [11:0] addr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [31:0] val,
                               input logic trap, input logic [1:0] sel,
                               input logic hi, input logic wr);
      vec_t v;
      v.mode = mode; v.f3 = f3; v.addr = addr; v.rd = rd; v.rs1 = rs1;
      v.rs1_val = val; v.trap = trap; v.sel = sel; v.hi = hi; v.wr = wr;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      cur           = v;
      req_valid     = 1'b1;
      req_insn      = {v.addr, v.rs1, v.f3, v.rd, 7'b1110011};
      req_rs1_rdata = v.rs1_val;
      req_mode      = v.mode;
   endtask

   task automatic check_resp(input exp_t e);
      chk("trap", resp_trap, e.trap);
      chk("rd_addr", resp_rd_addr, e.rd_addr);
      chk("rd_wdata", resp_rd_wdata, e.rd_wdata);
      chk("misa_rmask", misa_rmask, e.misa_rmask);
      chk("misa_wmask", misa_wmask, 0);
      chk("cyc_rmask", cyc_rmask, e.cyc_rmask);
      chk("cyc_wmask", cyc_wmask, e.cyc_wmask);
      chk("ins_rmask", ins_rmask, e.ins_rmask);
      chk("ins_wmask", ins_wmask, e.ins_wmask);
      if (e.misa_rmask != 0) begin
         chk("misa_rdata", misa_rdata, e.misa_rdata);
         chk("misa_wdata", misa_wdata, e.misa_wdata);
      end
      if (e.cyc_rmask != 0) chk("cyc_rdata", cyc_rdata, e.cyc_rdata);
      if (e.cyc_wmask != 0) chk("cyc_wdata", cyc_wdata, e.cyc_wdata);
      if (e.ins_rmask != 0) chk("ins_rdata", ins_rdata, e.ins_rdata);
      if (e.ins_wmask != 0) chk("ins_wdata", ins_wdata, e.ins_wdata);
   endtask

   // One clock: check the held response, predict this edge, advance the model.
   task automatic step();
      logic        acc, hs;
      logic [63:0] c_nx, i_nx, pm, pd, old64;
      logic [31:0] old32, arg, new32;
      exp_t        e;
      #1;
      acc = req_valid && (!m_rv || resp_ready);
      hs  = m_rv && resp_ready;
      chk("req_ready", req_ready, !m_rv || resp_ready);
      chk("resp_valid", resp_valid, m_rv);
      if (m_rv) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: response present, none expected");
         end else begin
            check_resp(sb[0]);
            if (hs) e = sb.pop_front();
         end
      end
      c_nx = m_cyc + 64'd1;
      i_nx = m_ins + 64'(retire_other) + 64'(hs);
      if (acc) begin
         e = '0;
         if (cur.trap) begin
            e.trap = 1'b1;
         end else begin
            if (cur.sel == S_MISA)     old64 = {32'h0, MISA};
            else if (cur.sel == S_CYC) old64 = m_cyc;
            else                       old64 = m_ins;
            old32 = cur.hi ? old64[63:32] : old64[31:0];
            arg   = cur.f3[2] ? {27'd0, cur.rs1} : cur.rs1_val;
            if (cur.f3[1:0] == 2'b01)      new32 = arg;
            else if (cur.f3[1:0] == 2'b10) new32 = old32 | arg;
            else                           new32 = old32 & ~arg;
            pm = cur.hi ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF;
            pd = cur.hi ? {new32, 32'h0} : {32'h0, new32};
            e.rd_addr  = cur.rd;
            e.rd_wdata = (cur.rd == 5'd0) ? 32'h0 : old32;
            if (cur.sel == S_MISA) begin
               e.misa_rmask = 32'hFFFF_FFFF;
               e.misa_rdata = MISA;
               e.misa_wdata = MISA;
            end else if (cur.sel == S_CYC) begin
               e.cyc_rmask = pm;
               e.cyc_rdata = m_cyc;
               if (cur.wr) begin
                  c_nx = (c_nx & ~pm) | (pd & pm);
                  e.cyc_wmask = pm;
               end
               e.cyc_wdata = c_nx;
            end else begin
               e.ins_rmask = pm;
               e.ins_rdata = m_ins;
               if (cur.wr) begin
                  i_nx = (i_nx & ~pm) | (pd & pm);
                  e.ins_wmask = pm;
               end
               e.ins_wdata = i_nx;
            end
         end
         sb.push_back(e);
      end
      @(posedge clock);
      m_cyc = c_nx;
      m_ins = i_nx;
      if (acc) m_rv = 1'b1;
      else if (hs) m_rv = 1'b0;
      @(negedge clock);
   endtask

   task automatic issue(input vec_t v);
      drive(v);
      step();
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      // mode, f3, addr, rd, rs1, rs1 value, trap, target, high half, write
      tab.push_back(mk(mode_m, 3'b010, 12'hB00,  5, 0, 32'h0,         0, S_CYC,  0, 0));
      tab.push_back(mk(mode_m, 3'b001, 12'hB02,  1, 2, 32'h1234,      0, S_INS,  0, 1));
      tab.push_back(mk(mode_u, 3'b011, 12'hB00,  3, 2, 32'hFF,        1, S_NONE, 0, 1));
      tab.push_back(mk(mode_m, 3'b101, 12'h301,  4, 5, 32'h0,         0, S_MISA, 0, 1));
      tab.push_back(mk(mode_m, 3'b010, 12'hB80,  6, 0, 32'h0,         0, S_CYC,  1, 0));
      tab.push_back(mk(mode_m, 3'b110, 12'hB82,  0, 0, 32'h0,         0, S_INS,  1, 0));
      tab.push_back(mk(mode_s, 3'b010, 12'hB02,  7, 0, 32'h0,         1, S_NONE, 0, 0));
      tab.push_back(mk(mode_m, 3'b010, 12'h340,  8, 0, 32'h0,         1, S_NONE, 0, 0));
      tab.push_back(mk(mode_u, 3'b010, 12'hC00,  9, 0, 32'h0, USER_TRAP, USER_SEL, 0, 0));
      tab.push_back(mk(mode_m, 3'b001, 12'hC02, 10, 1, 32'h5,         1, S_NONE, 0, 1));
      tab.push_back(mk(mode_m, 3'b011, 12'hB00, 11, 3, 32'hF,         0, S_CYC,  0, 1));
      tab.push_back(mk(mode_m, 3'b010, 12'hB02, 12, 4, 32'h8000_0000, 0, S_INS,  0, 1));
      tab.push_back(mk(mode_m, 3'b111, 12'h301, 13, 0, 32'h0,         0, S_MISA, 0, 0));
      tab.push_back(mk(mode_m, 3'b001, 12'hB80, 14, 6, 32'h0,         0, S_CYC,  1, 1));
      tab.push_back(mk(mode_m, 3'b101, 12'hB82, 15, 7, 32'h0,         0, S_INS,  1, 1));
      tab.push_back(mk(mode_m, 3'b010, 12'hB81, 16, 0, 32'h0,         1, S_NONE, 0, 0));

      // reset state
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_trap", resp_trap, 0);
      chk("rst_rd_wdata", resp_rd_wdata, 0);
      chk("rst_cyc_rmask", cyc_rmask, 0);
      chk("rst_ins_rdata", ins_rdata, 0);
      resetn = 1'b1;

      // 10 idle cycles then CSRRS x5, mcycle, x0
      idle(10);
      issue(mk(mode_m, 3'b010, 12'hB00, 5, 0, 32'h0, 0, S_CYC, 0, 0));
      chk("mcycle_after_10", resp_rd_wdata, 64'd10);
      chk("mcycle_rmask_lo", cyc_rmask, 64'h0000_0000_FFFF_FFFF);
      chk("mcycle_read_wmask", cyc_wmask, 0);
      step();

      // CSRRW x1, minstret, 0x1234 then read after it retires
      issue(mk(mode_m, 3'b001, 12'hB02, 1, 2, 32'h1234, 0, S_INS, 0, 1));
      chk("minstret_wdata", ins_wdata[31:0], 32'h1234);
      chk("minstret_wmask", ins_wmask, 64'h0000_0000_FFFF_FFFF);
      step();
      issue(mk(mode_m, 3'b010, 12'hB02, 2, 0, 32'h0, 0, S_INS, 0, 0));
      chk("minstret_reread", resp_rd_wdata, 64'h1235);
      step();

      // table, back to back, random other retirements
      foreach (tab[i]) begin
         retire_other = 1'($urandom_range(0, 1));
         drive(tab[i]);
         step();
      end
      req_valid = 1'b0;
      retire_other = 1'b0;
      step();

      // force mcycle near the top and let it wrap
      drive(mk(mode_m, 3'b001, 12'hB80, 1, 1, 32'hFFFF_FFFF, 0, S_CYC, 1, 1));
      step();
      drive(mk(mode_m, 3'b001, 12'hB00, 1, 1, 32'hFFFF_FFFE, 0, S_CYC, 0, 1));
      step();
      req_valid = 1'b0;
      idle(3);
      issue(mk(mode_m, 3'b010, 12'hB00, 8, 0, 32'h0, 0, S_CYC, 0, 0));
      chk("wrap_mcycle", cyc_rdata, 64'h1);
      chk("wrap_rd", resp_rd_wdata, 64'h1);
      issue(mk(mode_m, 3'b010, 12'hB80, 9, 0, 32'h0, 0, S_CYC, 1, 0));
      chk("wrap_mcycleh", resp_rd_wdata, 64'h0);
      chk("wrap_mcycleh_rmask", cyc_rmask, 64'hFFFF_FFFF_0000_0000);
      step();

      // back-pressure: response held 5 cycles while the next request waits
      resp_ready = 1'b0;
      issue(mk(mode_m, 3'b010, 12'hB02, 3, 0, 32'h0, 0, S_INS, 0, 0));
      drive(mk(mode_m, 3'b011, 12'hB00, 4, 5, 32'h1, 0, S_CYC, 0, 1));
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      chk("stall_drained", resp_valid, 0);

      // reset while a response is pending
      issue(mk(mode_m, 3'b010, 12'hB00, 6, 0, 32'h0, 0, S_CYC, 0, 0));
      chk("pending_before_rst", resp_valid, 1);
      resetn = 1'b0;
      #1;
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_rd_wdata", resp_rd_wdata, 0);
      chk("midrst_cyc_rmask", cyc_rmask, 0);
      m_cyc = '0; m_ins = '0; m_rv = 1'b0;
      sb.delete();
      @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      idle(3);
      issue(mk(mode_m, 3'b010, 12'hB00, 7, 0, 32'h0, 0, S_CYC, 0, 0));
      chk("mcycle_after_rst", resp_rd_wdata, 64'd3);
      step();
      chk("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
